// File: rtl/rpc2_ctrl_arb_pkg.sv
// Shared constants and helpers for the RPC2 controller address arbiter.
package rpc2_ctrl_arb_pkg;

  // Largest channel count the arbiter is intended to serve.
  localparam int ARB_MAX_CH = 8;

  // Channel index width: clog2 of the channel count, never below one bit.
  function automatic int ch_idx_w(input int num_ch);
    return (num_ch <= 2) ? 1 : $clog2(num_ch);
  endfunction

  // Largest weight value a weight field of the given width can hold.
  function automatic int max_weight(input int weight_width);
    return (1 << weight_width) - 1;
  endfunction

endpackage

// File: rtl/rpc2_ctrl_rr_search.sv
// Rotating first-eligible search: scans start, start+1, ... modulo C_NUM_CH.
module rpc2_ctrl_rr_search #(
  parameter int C_NUM_CH = 4,
  parameter int CH_IDX_W = 2
) (
  input  logic [C_NUM_CH-1:0] eligible,
  input  logic [CH_IDX_W-1:0] start,
  output logic                found,
  output logic [CH_IDX_W-1:0] index
);

  // First eligible channel at or after start, wrapping once around the ring.
  always_comb begin
    int c;
    c     = 0;
    found = 1'b0;
    index = '0;
    for (int k = 0; k < C_NUM_CH; k++) begin
      c = int'(start) + k;
      if (c >= C_NUM_CH) c = c - C_NUM_CH;
      if (!found && eligible[c]) begin
        found = 1'b1;
        index = CH_IDX_W'(c);
      end
    end
  end

endmodule

// File: rtl/rpc2_ctrl_addr_wrr_arbiter.sv
// Weighted round-robin arbiter feeding the ADR FIFO: each channel keeps the
// grant for weight+1 accepted requests before the turn moves on.
//
// Handshakes: a transfer happens on any cycle where valid and ready are both
// high. req_ready is combinational and only high in the grant cycle; arb_valid
// holds with arb_din/arb_ch stable until arb_ready is seen high.
module rpc2_ctrl_addr_wrr_arbiter
  import rpc2_ctrl_arb_pkg::*;
#(
  parameter int C_NUM_CH       = 4,
  parameter int C_DIN_WIDTH    = 48,
  parameter int C_WEIGHT_WIDTH = 2,
  localparam int CH_IDX_W      = ch_idx_w(C_NUM_CH)
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic [C_NUM_CH-1:0]                req_valid,
  input  logic [C_NUM_CH*C_DIN_WIDTH-1:0]    req_din,
  output logic [C_NUM_CH-1:0]                req_ready,
  input  logic [C_NUM_CH*C_WEIGHT_WIDTH-1:0] ch_weight,
  input  logic [C_NUM_CH-1:0]                ch_mask,
  output logic                               arb_valid,
  output logic [C_DIN_WIDTH-1:0]             arb_din,
  output logic [CH_IDX_W-1:0]                arb_ch,
  input  logic                               arb_ready
);

  localparam int USED_W = C_WEIGHT_WIDTH + 1;
  // Reset value of used: one past the largest weight, so the turn is exhausted.
  localparam logic [USED_W-1:0] USED_EXHAUSTED = USED_W'(max_weight(C_WEIGHT_WIDTH) + 1);
  localparam logic [CH_IDX_W-1:0] LAST_CH = CH_IDX_W'(C_NUM_CH - 1);

  logic [CH_IDX_W-1:0]       cur_ch;
  logic [USED_W-1:0]         used;
  logic [C_NUM_CH-1:0]       eligible;
  logic                      load_en;
  logic [C_WEIGHT_WIDTH-1:0] cur_weight;
  logic                      stay;
  logic [CH_IDX_W-1:0]       search_start;
  logic                      search_found;
  logic [CH_IDX_W-1:0]       search_idx;
  logic                      grant_valid;
  logic [CH_IDX_W-1:0]       grant_ch;
  logic [C_DIN_WIDTH-1:0]    grant_din;

  assign eligible     = req_valid & ~ch_mask;
  assign load_en      = ~arb_valid | arb_ready;
  assign search_start = (cur_ch == LAST_CH) ? '0 : cur_ch + CH_IDX_W'(1);

  rpc2_ctrl_rr_search #(
    .C_NUM_CH (C_NUM_CH),
    .CH_IDX_W (CH_IDX_W)
  ) u_search (
    .eligible (eligible),
    .start    (search_start),
    .found    (search_found),
    .index    (search_idx)
  );

  // Grant decision: keep the current owner while it has credit left (live
  // weight), otherwise hand the turn to the next eligible channel.
  always_comb begin
    cur_weight  = ch_weight[int'(cur_ch)*C_WEIGHT_WIDTH +: C_WEIGHT_WIDTH];
    stay        = eligible[cur_ch] && (used <= {1'b0, cur_weight});
    grant_valid = reset_n && load_en && (stay || search_found);
    grant_ch    = stay ? cur_ch : search_idx;
    grant_din   = req_din[int'(grant_ch)*C_DIN_WIDTH +: C_DIN_WIDTH];
  end

  // One-hot accept to the granted channel, silent during reset.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < C_NUM_CH; i++) begin
      req_ready[i] = grant_valid && (grant_ch == CH_IDX_W'(i));
    end
  end

  // Turn state and output register; both only move when the output slot frees.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur_ch    <= LAST_CH;
      used      <= USED_EXHAUSTED;
      arb_valid <= 1'b0;
      arb_din   <= '0;
      arb_ch    <= '0;
    end else if (load_en) begin
      if (grant_valid) begin
        arb_valid <= 1'b1;
        arb_din   <= grant_din;
        arb_ch    <= grant_ch;
        if (stay) begin
          used <= used + USED_W'(1);
        end else begin
          cur_ch <= grant_ch;
          used   <= USED_W'(1);
        end
      end else begin
        arb_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rpc2_ctrl_addr_wrr_arbiter.sv
// Bench for the weighted round-robin address arbiter: directed scenarios plus
// a randomized phase, all checked against a turn/credit reference model.
module tb_rpc2_ctrl_addr_wrr_arbiter;

  localparam int N  = 4;
  localparam int DW = 48;
  localparam int WW = 2;
  localparam int IW = 2;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [N-1:0]      req_valid;
  logic [N*DW-1:0]   req_din;
  logic [N-1:0]      req_ready;
  logic [N*WW-1:0]   ch_weight;
  logic [N-1:0]      ch_mask;
  logic              arb_valid;
  logic [DW-1:0]     arb_din;
  logic [IW-1:0]     arb_ch;
  logic              arb_ready;

  // Reference model: who owns the turn and how many grants it has had.
  int            m_owner;
  int            m_taken;
  logic          m_valid;
  logic [DW-1:0] m_din;
  int            m_ch;

  int n_tests = 0;
  int n_fail  = 0;

  rpc2_ctrl_addr_wrr_arbiter #(
    .C_NUM_CH       (N),
    .C_DIN_WIDTH    (DW),
    .C_WEIGHT_WIDTH (WW)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_din   (req_din),
    .req_ready (req_ready),
    .ch_weight (ch_weight),
    .ch_mask   (ch_mask),
    .arb_valid (arb_valid),
    .arb_din   (arb_din),
    .arb_ch    (arb_ch),
    .arb_ready (arb_ready)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int weight_of(input int i);
    return int'(ch_weight[i*WW +: WW]);
  endfunction

  function automatic bit elig(input int i);
    return req_valid[i] && !ch_mask[i];
  endfunction

  task automatic model_reset();
    m_owner = N - 1;
    m_taken = 1 << WW;
    m_valid = 1'b0;
    m_din   = '0;
    m_ch    = 0;
  endtask

  task automatic rand_payload();
    for (int i = 0; i < N; i++) begin
      req_din[i*DW +: DW] = {$urandom, $urandom};
    end
  endtask

  // One clock: inputs are already driven; check req_ready, advance the model,
  // then check the registered output after the edge.
  task automatic cycle(input string tag);
    int g;
    int c;
    logic [N-1:0] exp_rdy;
    bit load;
    bit keep;
    #1;
    load = !m_valid || arb_ready;
    g    = -1;
    keep = 0;
    if (load) begin
      if (elig(m_owner) && m_taken < weight_of(m_owner) + 1) begin
        g    = m_owner;
        keep = 1;
      end else begin
        for (int k = 1; k <= N; k++) begin
          c = (m_owner + k) % N;
          if (g < 0 && elig(c)) g = c;
        end
      end
    end
    exp_rdy = (g >= 0) ? N'(1 << g) : '0;
    chk({tag, "/req_ready"}, 64'(req_ready), 64'(exp_rdy));
    if (load) begin
      if (g >= 0) begin
        if (keep) m_taken++;
        else begin
          m_owner = g;
          m_taken = 1;
        end
        m_valid = 1'b1;
        m_din   = req_din[g*DW +: DW];
        m_ch    = g;
      end else begin
        m_valid = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    chk({tag, "/arb_valid"}, 64'(arb_valid), 64'(m_valid));
    if (m_valid) begin
      chk({tag, "/arb_ch"},  64'(arb_ch),  64'(m_ch));
      chk({tag, "/arb_din"}, 64'(arb_din), 64'(m_din));
    end
  endtask

  // Asynchronous reset pulse taken mid-cycle; outputs must drop immediately.
  task automatic do_reset(input string tag);
    reset_n = 1'b0;
    #1;
    chk({tag, "/rst_valid"}, 64'(arb_valid), 64'd0);
    chk({tag, "/rst_ready"}, 64'(req_ready), 64'd0);
    chk({tag, "/rst_ch"},    64'(arb_ch),    64'd0);
    chk({tag, "/rst_din"},   64'(arb_din),   64'd0);
    model_reset();
    @(posedge clk);
    #1;
    chk({tag, "/rst_hold"}, 64'(req_ready), 64'd0);
    reset_n = 1'b1;
  endtask

  initial begin : stim
    int seq [12];
    logic [DW-1:0] held_din;
    int held_ch;
    seq = '{0, 1, 1, 2, 2, 2, 3, 3, 3, 3, 0, 1};

    reset_n   = 1'b1;
    req_valid = '0;
    req_din   = '0;
    ch_weight = '0;
    ch_mask   = '0;
    arb_ready = 1'b1;
    model_reset();
    #2;
    do_reset("init");

    // Weights 0..3, everyone requesting: fixed grant pattern.
    ch_weight = {2'd3, 2'd2, 2'd1, 2'd0};
    req_valid = '1;
    for (int i = 0; i < 12; i++) begin
      rand_payload();
      cycle("wrr");
      chk("wrr/seq", 64'(arb_ch), 64'(seq[i]));
    end

    // Lone channel 1 with weight 0: back-to-back grants, no gaps.
    do_reset("lone");
    ch_weight = '0;
    req_valid = 4'b0010;
    for (int i = 0; i < 5; i++) begin
      rand_payload();
      cycle("lone");
      chk("lone/ch", 64'(arb_ch), 64'd1);
      chk("lone/valid", 64'(arb_valid), 64'd1);
    end

    // Downstream stall for 3 cycles, then accept and reload in the same cycle.
    req_valid = '1;
    ch_weight = {2'd1, 2'd0, 2'd2, 2'd1};
    rand_payload();
    cycle("stall_fill");
    held_din  = m_din;
    held_ch   = m_ch;
    arb_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rand_payload();
      cycle("stall");
      chk("stall/din_held", 64'(arb_din), 64'(held_din));
      chk("stall/ch_held",  64'(arb_ch),  64'(held_ch));
    end
    arb_ready = 1'b1;
    rand_payload();
    cycle("stall_release");
    chk("stall_release/valid", 64'(arb_valid), 64'd1);

    // All weights 3: mask channel 2 after its second grant.
    do_reset("mask");
    ch_weight = '1;
    req_valid = '1;
    for (int i = 0; i < 10; i++) begin
      rand_payload();
      cycle("mask_pre");
    end
    chk("mask/ch2_twice", 64'(arb_ch), 64'd2);
    ch_mask = 4'b0100;
    rand_payload();
    cycle("mask_first");
    chk("mask/next_is_3", 64'(arb_ch), 64'd3);
    for (int i = 0; i < 8; i++) begin
      rand_payload();
      cycle("mask_run");
      chk("mask/no_ch2", 64'(arb_ch == 2'd2), 64'd0);
    end
    ch_mask = '0;
    for (int i = 0; i < 6; i++) begin
      rand_payload();
      cycle("unmask");
    end

    // Reset mid-burst, then first grant goes to channel 0.
    do_reset("midburst");
    rand_payload();
    cycle("post_rst");
    chk("post_rst/ch0", 64'(arb_ch), 64'd0);

    // Owner 3 exhausted, only 0 and 3 requesting: wrap to 0 with a fresh turn.
    do_reset("wrap");
    ch_weight = '0;
    req_valid = '1;
    for (int i = 0; i < 4; i++) begin
      rand_payload();
      cycle("wrap_pre");
    end
    chk("wrap/owner3", 64'(arb_ch), 64'd3);
    req_valid = 4'b1001;
    rand_payload();
    cycle("wrap");
    chk("wrap/ch0", 64'(arb_ch), 64'd0);
    ch_weight = {2'd0, 2'd0, 2'd0, 2'd1};
    rand_payload();
    cycle("wrap_used1");
    chk("wrap/ch0_again", 64'(arb_ch), 64'd0);
    rand_payload();
    cycle("wrap_exhaust");
    chk("wrap/ch3", 64'(arb_ch), 64'd3);

    // Randomized traffic, masks, live weights and backpressure.
    for (int i = 0; i < 400; i++) begin
      req_valid = N'($urandom_range(0, (1 << N) - 1));
      ch_mask   = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, (1 << N) - 1)) : '0;
      if ($urandom_range(0, 7) == 0) ch_weight = (N*WW)'($urandom);
      arb_ready = ($urandom_range(0, 3) != 0);
      rand_payload();
      cycle("rand");
      if (i == 200) do_reset("rand_rst");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rpc2_ctrl_addr_wrr_arbiter.md
RPC2_CTRL_ADDR_WRR_ARBITER -- requirements
Module: rpc2_ctrl_addr_wrr_arbiter

Interface
REQ-001 SHALL have parameter C_NUM_CH, default 4, number of request channels (legal 2..8).
REQ-002 SHALL have parameter C_DIN_WIDTH, default 48, payload bits per channel (addr+len+burst+size+r/w+block).
REQ-003 SHALL have parameter C_WEIGHT_WIDTH, default 2, bits per channel weight.
REQ-004 SHALL derive localparam CH_IDX_W = max(1, clog2(C_NUM_CH)).
REQ-005 SHALL have port clk  in  1  sole clock, rising edge.
REQ-006 SHALL have port reset_n  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port req_valid  in  C_NUM_CH  per-channel request valid.
REQ-008 SHALL have port req_din  in  C_NUM_CH*C_DIN_WIDTH  payloads; channel i at [i*C_DIN_WIDTH +: C_DIN_WIDTH].
REQ-009 SHALL have port req_ready  out  C_NUM_CH  per-channel accept, at most one bit set per cycle.
REQ-010 SHALL have port ch_weight  in  C_NUM_CH*C_WEIGHT_WIDTH  per-channel weight; channel gets weight+1 grants per turn.
REQ-011 SHALL have port ch_mask  in  C_NUM_CH  1 = channel excluded from arbitration.
REQ-012 SHALL have port arb_valid  out  1  output entry valid.
REQ-013 SHALL have port arb_din  out  C_DIN_WIDTH  output payload.
REQ-014 SHALL have port arb_ch  out  CH_IDX_W  source channel of arb_din.
REQ-015 SHALL have port arb_ready  in  1  downstream accept (ADR FIFO write ready).

Function
REQ-016 SHALL treat channel i as eligible when req_valid[i] & ~ch_mask[i].
REQ-017 SHALL hold state cur_ch (CH_IDX_W bits) and used (C_WEIGHT_WIDTH+1 bits, grants given in current turn).
REQ-018 SHALL define load_en = ~arb_valid | arb_ready; no grant when load_en=0, state unchanged.
REQ-019 SHALL, when load_en and cur_ch eligible and used <= ch_weight[cur_ch], grant cur_ch and set used <= used+1.
REQ-020 SHALL otherwise grant the first eligible channel searching cur_ch+1, cur_ch+2, ... wrapping modulo C_NUM_CH and ending at cur_ch; set cur_ch <= granted channel and used <= 1.
REQ-021 SHALL, with no eligible channel, grant nothing and leave cur_ch/used unchanged.
REQ-022 SHALL assert req_ready[g] combinationally in the grant cycle only; the req_valid&req_ready handshake is the transfer.
REQ-023 SHALL register the granted payload and channel into arb_din/arb_ch with arb_valid=1 on the next rising edge: latency exactly 1 cycle.
REQ-024 SHALL clear arb_valid after arb_valid&arb_ready when no new grant occurs that cycle; a simultaneous accept and grant SHALL keep arb_valid=1 (full throughput, 1 entry/cycle).
REQ-025 SHALL keep arb_din/arb_ch stable while arb_valid & ~arb_ready.
REQ-026 SHALL compare against live ch_weight; a weight decrease below used ends the turn at the next grant decision.
REQ-027 SHALL skip a channel masked mid-turn per REQ-020; its unused credit is lost.

Reset
REQ-028 SHALL on reset_n low asynchronously set arb_valid=0, arb_din=0, arb_ch=0, cur_ch=C_NUM_CH-1, used=2^C_WEIGHT_WIDTH (exhausted), so the first grant searches from channel 0.
REQ-029 SHALL drive req_ready=0 throughout reset; an entry held at reset assertion is discarded.

Structure
REQ-030 SHALL place CH_IDX_W computation and the max weight constant in shared package rpc2_ctrl_arb_pkg.
REQ-031 SHALL implement the rotating search of REQ-020 in sub-module rpc2_ctrl_rr_search (inputs eligible vector, start index; outputs found, index).

Verification
REQ-032 SHALL test: C_NUM_CH=4, weights {0,1,2,3}, all valid, mask 0, arb_ready=1 -> arb_ch sequence 0,1,1,2,2,2,3,3,3,3,0,1,... one per cycle.
REQ-033 SHALL test: ch1 only valid, ch1 weight 0, 5 requests -> 5 consecutive grants to ch1, no gaps.
REQ-034 SHALL test: arb_ready=0 for 3 cycles with arb_valid=1 -> req_ready all 0, arb_din/arb_ch unchanged; first cycle arb_ready=1 -> new grant same cycle, arb_valid stays 1.
REQ-035 SHALL test: weights all 3, ch2 masked after its 2nd grant -> next grant ch3, ch2 absent until unmasked.
REQ-036 SHALL test: reset_n low mid-burst -> arb_valid=0 immediately; after release with all valid, first arb_ch=0.
REQ-037 SHALL test: cur_ch=3 exhausted, only ch0 and ch3 valid -> grant ch0 (wrap), used=1.
